// File: rtl/led_pwm_pkg.sv
// Shared definitions for the AXI4-Lite LED PWM controller: register offsets,
// AXI response codes, LED mode encoding and bus FSM state types.
package led_pwm_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_PRESCALE = 8'h04;
    localparam logic [7:0] OFF_BLINK    = 8'h08;
    localparam logic [7:0] OFF_INFO     = 8'h0C;
    localparam logic [7:0] OFF_LED0     = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_PWM   = 2'd2,
        MODE_BLINK = 2'd3
    } led_mode_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/led_pwm_chan.sv
// One LED channel: duty comparator and mode selection, combinational.
// The owning block registers the result onto the LED pin.
module led_pwm_chan
    import led_pwm_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  led_mode_e              mode_i,
    input  logic [PWM_WIDTH-1:0]   duty_i,
    input  logic [PWM_WIDTH-1:0]   pwm_cnt_i,
    input  logic                   phase_i,
    output logic                   on_o
);

    logic pwm_hi;

    // The counter never reaches all-ones, so duty=all-ones is solidly on.
    assign pwm_hi = (pwm_cnt_i < duty_i);

    always_comb begin
        on_o = 1'b0;
        case (mode_i)
            MODE_OFF:   on_o = 1'b0;
            MODE_ON:    on_o = 1'b1;
            MODE_PWM:   on_o = pwm_hi;
            MODE_BLINK: on_o = pwm_hi & phase_i;
        endcase
    end

endmodule

// File: rtl/led_pwm_axil.sv
// AXI4-Lite controlled multi-channel LED PWM driver with a shared prescaler,
// PWM period counter and blink phase generator.
module led_pwm_axil
    import led_pwm_pkg::*;
#(
    parameter int NUM_LEDS           = 4,
    parameter int PWM_WIDTH          = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]                    AWPROT,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [31:0]                   WDATA,
    input  logic [3:0]                    WSTRB,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]                    ARPROT,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [31:0]                   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RVALID,
    input  logic                          RREADY,
    output logic [NUM_LEDS-1:0]           LED
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [PWM_WIDTH-1:0] PWM_LAST = {{(PWM_WIDTH-1){1'b1}}, 1'b0};

    // Bus state
    wr_state_e                   wr_state_q, wr_state_d;
    rd_state_e                   rd_state_q, rd_state_d;
    logic                        rdy_en_q;
    logic                        aw_held_q, w_held_q;
    logic [AW-1:0]               aw_addr_q;
    logic [31:0]                 w_data_q;
    logic [3:0]                  w_strb_q;
    logic [1:0]                  bresp_q, rresp_q;
    logic [31:0]                 rdata_q;
    logic                        do_write;

    // Register file
    logic                        ctrl_q;
    logic [15:0]                 prescale_q, blink_half_q;
    led_mode_e [NUM_LEDS-1:0]    mode_q;
    logic [NUM_LEDS-1:0][PWM_WIDTH-1:0] duty_q;

    // Timing chain
    logic [15:0]                 pre_cnt_q, blink_cnt_q;
    logic [PWM_WIDTH-1:0]        pwm_cnt_q;
    logic                        phase_q;
    logic                        tick, wrap, period_end, restart;
    logic [NUM_LEDS-1:0]         led_d, led_q;

    // Decode
    logic [NUM_LEDS-1:0]         wr_led_hit, rd_led_hit;
    logic [NUM_LEDS-1:0][31:0]   led_word;
    logic                        wr_mapped, wr_ok, rd_mapped;
    logic [31:0]                 wr_cur, wr_mask, wr_merged, rd_cur;

    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    function automatic logic is_off(input logic [AW-1:0] a, input logic [7:0] off);
        logic [AW-1:0] o;
        o = AW'(off);
        return a[AW-1:2] == o[AW-1:2];
    endfunction

    // Returns {mapped, readback word}; unmapped addresses read as zero.
    function automatic logic [32:0] reg_read(input logic [AW-1:0] a,
                                             input logic [NUM_LEDS-1:0] led_hit);
        logic [32:0] r;
        r = '0;
        if (is_off(a, OFF_CTRL))          r = {1'b1, 31'b0, ctrl_q};
        else if (is_off(a, OFF_PRESCALE)) r = {1'b1, 16'b0, prescale_q};
        else if (is_off(a, OFF_BLINK))    r = {1'b1, 16'b0, blink_half_q};
        else if (is_off(a, OFF_INFO))     r = {1'b1, 16'b0, 8'(PWM_WIDTH), 8'(NUM_LEDS)};
        else begin
            for (int k = 0; k < NUM_LEDS; k++) begin
                if (led_hit[k]) r = {1'b1, led_word[k]};
            end
        end
        return r;
    endfunction

    for (genvar k = 0; k < NUM_LEDS; k++) begin : g_chan
        localparam logic [AW-1:0] LED_ADDR = AW'(int'(OFF_LED0) + 4 * k);
        assign wr_led_hit[k] = (aw_addr_q[AW-1:2] == LED_ADDR[AW-1:2]);
        assign rd_led_hit[k] = (ARADDR[AW-1:2] == LED_ADDR[AW-1:2]);
        assign led_word[k]   = 32'({duty_q[k], 6'b0, mode_q[k]});

        led_pwm_chan #(.PWM_WIDTH(PWM_WIDTH)) u_chan (
            .mode_i    (mode_q[k]),
            .duty_i    (duty_q[k]),
            .pwm_cnt_i (pwm_cnt_q),
            .phase_i   (phase_q),
            .on_o      (led_d[k])
        );
    end

    always_comb begin
        wr_mask   = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
        {wr_mapped, wr_cur} = reg_read(aw_addr_q, wr_led_hit);
        {rd_mapped, rd_cur} = reg_read(ARADDR, rd_led_hit);
        wr_ok     = wr_mapped && !is_off(aw_addr_q, OFF_INFO);
        wr_merged = (wr_cur & ~wr_mask) | (w_data_q & wr_mask);
    end

    // Ready outputs stay low until the first edge after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rdy_en_q <= 1'b0;
        else          rdy_en_q <= 1'b1;
    end

    assign AWREADY = rdy_en_q && (wr_state_q == W_IDLE) && !aw_held_q;
    assign WREADY  = rdy_en_q && (wr_state_q == W_IDLE) && !w_held_q;
    assign BVALID  = (wr_state_q == W_RESP);
    assign BRESP   = bresp_q;
    assign ARREADY = rdy_en_q && (rd_state_q == R_IDLE);
    assign RVALID  = (rd_state_q == R_DATA);
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        do_write   = 1'b0;
        case (wr_state_q)
            W_IDLE: if (aw_held_q && w_held_q) begin
                do_write   = 1'b1;
                wr_state_d = W_RESP;
            end
            W_RESP: if (BREADY) wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE: if (ARVALID && ARREADY) rd_state_d = R_DATA;
            R_DATA: if (RREADY) rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            if (wr_state_q == W_RESP && BREADY) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (AWVALID && AWREADY) begin
                    aw_held_q <= 1'b1;
                    aw_addr_q <= AWADDR;
                end
                if (WVALID && WREADY) begin
                    w_held_q <= 1'b1;
                    w_data_q <= WDATA;
                    w_strb_q <= WSTRB;
                end
            end
            if (do_write) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            // Read samples the registers before any same-edge write lands.
            if (ARVALID && ARREADY) begin
                rdata_q <= rd_cur;
                rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_q       <= 1'b0;
            prescale_q   <= '0;
            blink_half_q <= '0;
            mode_q       <= '{default: MODE_OFF};
            duty_q       <= '0;
        end else if (do_write && wr_ok) begin
            if (is_off(aw_addr_q, OFF_CTRL))     ctrl_q       <= wr_merged[0];
            if (is_off(aw_addr_q, OFF_PRESCALE)) prescale_q   <= wr_merged[15:0];
            if (is_off(aw_addr_q, OFF_BLINK))    blink_half_q <= wr_merged[15:0];
            for (int k = 0; k < NUM_LEDS; k++) begin
                if (wr_led_hit[k]) begin
                    mode_q[k] <= led_mode_e'(wr_merged[1:0]);
                    duty_q[k] <= wr_merged[8 +: PWM_WIDTH];
                end
            end
        end
    end

    assign restart    = do_write && wr_ok &&
                        (is_off(aw_addr_q, OFF_PRESCALE) || is_off(aw_addr_q, OFF_BLINK));
    assign tick       = (pre_cnt_q == prescale_q);
    assign wrap       = (pwm_cnt_q == PWM_LAST);
    assign period_end = tick && wrap;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (!ctrl_q || restart) begin
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            if (!ctrl_q) phase_q <= 1'b0;
        end else begin
            pre_cnt_q <= tick ? 16'd0 : pre_cnt_q + 16'd1;
            if (tick) pwm_cnt_q <= wrap ? '0 : pwm_cnt_q + PWM_WIDTH'(1);
            if (period_end) begin
                if (blink_cnt_q == blink_half_q) begin
                    blink_cnt_q <= '0;
                    phase_q     <= ~phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) led_q <= '0;
        else          led_q <= ctrl_q ? led_d : '0;
    end

    assign LED = led_q;

endmodule

// File: tb/tb_led_pwm_axil.sv
// Directed bench for led_pwm_axil: register access table plus PWM, blink,
// handshake-ordering and reset-abort sequences.
module tb_led_pwm_axil;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [6:0]  AWADDR, ARADDR;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic [3:0]  LED;

    int passed = 0;
    int total  = 0;

    led_pwm_axil #(.NUM_LEDS(4), .PWM_WIDTH(8), .C_S_AXI_ADDR_WIDTH(7)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .LED(LED)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        AWADDR = a; AWVALID = 1'b1;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            step();
            if (aw_hs) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin WVALID  = 1'b0; w_done  = 1'b1; end
            n++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        BREADY = 1'b1; n = 0;
        while (!BVALID && n < 20) begin step(); n++; end
        check("wr_bvalid_seen", BVALID, 1);
        resp = BVALID ? BRESP : 2'b11;
        step();
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        ARADDR = a; ARVALID = 1'b1; n = 0;
        while (!ARREADY && n < 20) begin step(); n++; end
        step();
        ARVALID = 1'b0; RREADY = 1'b1; n = 0;
        while (!RVALID && n < 20) begin step(); n++; end
        check("rd_rvalid_seen", RVALID, 1);
        d = RDATA; resp = RRESP;
        step();
        RREADY = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int n, hi0, hi1, hi3, bv;
        logic prev;

        vecs[0] = '{7'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0000BEEF, 2'b00};
        vecs[1] = '{7'h04, 32'h00001234, 4'h2, 2'b00, 32'h000012EF, 2'b00};
        vecs[2] = '{7'h08, 32'h0000ABCD, 4'h3, 2'b00, 32'h0000ABCD, 2'b00};
        vecs[3] = '{7'h00, 32'hFFFFFFFF, 4'hE, 2'b00, 32'h00000000, 2'b00};
        vecs[4] = '{7'h0C, 32'h00000000, 4'hF, 2'b10, 32'h00000804, 2'b00};
        vecs[5] = '{7'h20, 32'h00000001, 4'hF, 2'b10, 32'h00000000, 2'b10};
        vecs[6] = '{7'h1C, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0000FF03, 2'b00};
        vecs[7] = '{7'h18, 32'h00005A02, 4'h1, 2'b00, 32'h00000002, 2'b00};
        vecs[8] = '{7'h40, 32'h12345678, 4'hF, 2'b10, 32'h00000000, 2'b10};
        vecs[9] = '{7'h10, 32'h00000001, 4'hF, 2'b00, 32'h00000001, 2'b00};

        ARESETN = 1'b0;
        AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) step();
        check("rst_awready", AWREADY, 0);
        check("rst_wready",  WREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid",  BVALID, 0);
        check("rst_rvalid",  RVALID, 0);
        check("rst_led",     LED, 0);
        ARESETN = 1'b1;
        step();
        check("post_rst_awready", AWREADY, 1);
        check("post_rst_arready", ARREADY, 1);

        for (int i = 0; i < NV; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, resp);
            check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_bresp);
            axi_read(vecs[i].addr, rd, resp);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_rresp);
        end

        // Enable and LED0 steady on
        axi_write(7'h00, 32'h1, 4'hF, resp);
        check("ctrl_en_bresp", resp, 2'b00);
        axi_write(7'h10, 32'h1, 4'hF, resp);
        check("led0_on", LED[0], 1);
        axi_read(7'h00, rd, resp);
        check("ctrl_readback", rd, 32'h1);

        // PWM duty 0x40, 0 and 0xFF with a tick every cycle
        axi_write(7'h04, 32'h0, 4'hF, resp);
        axi_write(7'h10, 32'h00000002, 4'hF, resp);
        axi_write(7'h1C, 32'h0000FF02, 4'hF, resp);
        axi_write(7'h14, 32'h00004002, 4'hF, resp);
        repeat (4) step();
        for (int w = 0; w < 2; w++) begin
            hi0 = 0; hi1 = 0; hi3 = 0;
            for (int i = 0; i < 255; i++) begin
                hi0 += int'(LED[0]); hi1 += int'(LED[1]); hi3 += int'(LED[3]);
                step();
            end
            check($sformatf("pwm40_hi_w%0d", w), hi1, 64);
            check($sformatf("pwm00_hi_w%0d", w), hi0, 0);
            check($sformatf("pwmFF_hi_w%0d", w), hi3, 255);
        end

        // Blink-pwm full duty: phase half-period of 2 PWM periods
        axi_write(7'h08, 32'h1, 4'hF, resp);
        axi_write(7'h18, 32'h0000FF03, 4'hF, resp);
        prev = LED[2]; n = 0;
        while (LED[2] == prev && n < 1200) begin step(); n++; end
        check("blink_first_edge", LED[2] != prev, 1);
        for (int e = 0; e < 2; e++) begin
            prev = LED[2]; n = 0;
            while (LED[2] == prev && n < 1200) begin step(); n++; end
            check($sformatf("blink_interval%0d", e), n, 510);
        end

        // Global disable blanks all outputs
        axi_write(7'h00, 32'h0, 4'hF, resp);
        repeat (2) step();
        check("disable_led", LED, 0);
        axi_write(7'h00, 32'h1, 4'hF, resp);

        // W three cycles ahead of AW, response held off for five cycles
        WDATA = 32'h00003301; WSTRB = 4'hF; WVALID = 1'b1;
        check("early_w_wready", WREADY, 1);
        step();
        WVALID = 1'b0;
        step(); step();
        check("no_bvalid_before_aw", BVALID, 0);
        AWADDR = 7'h10; AWVALID = 1'b1;
        check("late_aw_awready", AWREADY, 1);
        step();
        AWVALID = 1'b0; n = 0;
        while (!BVALID && n < 10) begin step(); n++; end
        check("split_bvalid", BVALID, 1);
        check("split_bresp", BRESP, 2'b00);
        bv = 0;
        for (int i = 0; i < 5; i++) begin
            bv += int'(BVALID);
            if (AWREADY || WREADY) bv += 100;
            step();
        end
        check("bvalid_held_5", bv, 5);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        check("bvalid_dropped", BVALID, 0);
        check("ready_after_resp", AWREADY, 1);
        axi_read(7'h10, rd, resp);
        check("split_readback", rd, 32'h00003301);

        // Reset while the response is pending
        AWADDR = 7'h14; AWVALID = 1'b1; WDATA = 32'h00000001; WSTRB = 4'hF; WVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b0; n = 0;
        while (!BVALID && n < 10) begin step(); n++; end
        check("abort_bvalid_pending", BVALID, 1);
        ARESETN = 1'b0;
        #1;
        check("abort_bvalid", BVALID, 0);
        check("abort_led", LED, 0);
        step();
        ARESETN = 1'b1;
        step();
        axi_write(7'h00, 32'h1, 4'hF, resp);
        check("post_abort_bresp", resp, 2'b00);
        axi_read(7'h00, rd, resp);
        check("post_abort_ctrl", rd, 32'h1);
        axi_read(7'h14, rd, resp);
        check("post_abort_led1", rd, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_pwm_axil.md
LED_PWM_AXIL -- requirements
Module: led_pwm_axil

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of LED channels, legal range 1..16.
REQ-002 SHALL have parameter PWM_WIDTH, default 8, duty/counter width, legal range 4..16.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 7, AXI4-Lite byte-address width.
REQ-004 SHALL have port ACLK  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port ARESETN  in  1  asynchronous active-low reset.
REQ-006 SHALL have AXI4-Lite slave ports AWADDR/AWPROT/AWVALID/AWREADY, WDATA(32)/WSTRB(4)/WVALID/WREADY, BRESP(2)/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA(32)/RRESP(2)/RVALID/RREADY, standard directions.
REQ-007 SHALL have port LED  out  NUM_LEDS  registered LED drive, 1 = lit.

Function
REQ-008 Register map SHALL be: 0x00 CTRL [0] global enable; 0x04 PRESCALE [15:0]; 0x08 BLINK_HALF [15:0]; 0x0C INFO read-only {PWM_WIDTH[15:8], NUM_LEDS[7:0]}; 0x10+4k LEDk [1:0] mode, [8+PWM_WIDTH-1:8] duty, k < NUM_LEDS.
REQ-009 Modes SHALL be: 0 off, 1 on, 2 pwm, 3 blink-pwm.
REQ-010 Write path SHALL be FSM W_IDLE -> W_RESP: AWREADY and WREADY high in W_IDLE; AW and W may arrive in either order or together; each latched independently; register update in the cycle both are held; BVALID asserted next cycle.
REQ-011 BVALID SHALL stay high until BREADY; return to W_IDLE the cycle after BVALID&BREADY; no new AW/W accepted while in W_RESP.
REQ-012 Writes SHALL honour WSTRB per byte; unimplemented bits read 0.
REQ-013 Writes to INFO, or to unmapped/out-of-range LED addresses, SHALL change nothing and return BRESP=SLVERR (2'b10); mapped writes return OKAY.
REQ-014 Read path SHALL be FSM R_IDLE -> R_DATA: ARREADY high in R_IDLE; RDATA/RVALID valid one cycle after AR handshake; held until RREADY; unmapped reads return 0 with RRESP=SLVERR.
REQ-015 Read and write FSMs SHALL be independent; a simultaneous read and write to one register returns the pre-write value.
REQ-016 Prescaler SHALL count 0..PRESCALE and emit one-cycle tick on reaching PRESCALE, then wrap to 0; PRESCALE=0 gives a tick every cycle.
REQ-017 PWM counter SHALL advance on tick over 0..2^PWM_WIDTH-2 and wrap to 0; period end = wrap.
REQ-018 PWM output SHALL be high while counter < duty; duty=0 always off; duty=all-ones always on.
REQ-019 Blink counter SHALL count period ends 0..BLINK_HALF and toggle a shared blink phase on reaching BLINK_HALF; mode 3 output = pwm AND phase.
REQ-020 LED[k] SHALL be registered, one cycle after the selecting condition; CTRL[0]=0 forces all LED low and holds prescaler, PWM and blink counters at 0.
REQ-021 Writing PRESCALE or BLINK_HALF SHALL restart the prescaler and both counters at 0 on the following cycle.

Reset
REQ-022 On ARESETN low all registers, counters, phase SHALL clear to 0, LED=0, AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, FSMs to idle.
REQ-023 Reset mid-transaction SHALL abandon it with no response; ready outputs assert the first cycle after ARESETN deasserts.

Structure
REQ-024 Shared package led_pwm_pkg SHALL hold register offset constants, mode enum, and FSM state typedefs.
REQ-025 Per-channel comparator/mode mux SHALL be sub-module led_pwm_chan instantiated NUM_LEDS times via generate.

Verification
REQ-026 Write CTRL=1, LED0=mode1 -> LED[0]=1 within 2 cycles after BVALID; readback 0x00000001.
REQ-027 PWM_WIDTH=8, PRESCALE=0, LED1 mode2 duty=0x40 -> LED[1] high 64 of every 255 cycles.
REQ-028 LED2 mode3 duty=0xFF, BLINK_HALF=1, PRESCALE=0 -> LED[2] toggles every 510 cycles.
REQ-029 W before AW by 3 cycles, BREADY held low 5 cycles -> single update, BVALID held 5 cycles, OKAY.
REQ-030 Write 0x10+4*NUM_LEDS and read 0x0C write -> SLVERR, INFO reads 0x00000804 at defaults.
REQ-031 ARESETN low during W_RESP -> BVALID=0, LED=0, next write completes normally.
